// File: rtl/bin8_to_ascii_converter_pkg.sv
// Shared definitions for the binary-to-ASCII converter.
//   conv_state_e   : converter FSM states
//   ASCII_ZERO     : ASCII code of character '0'
//   ASCII_ERR      : ASCII code emitted for a non-decimal nibble ('?')
//   BCD_DIGITS     : number of BCD digits produced
//   bcd_add3       : double-dabble correction for a single nibble
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_ERR  = 8'h3F;
    localparam int         BCD_DIGITS = 3;

    // A nibble of 5 or more would overflow past 9 when doubled, so it is
    // pre-biased by 3 before the shift to carry correctly into the next digit.
    function automatic logic [3:0] bcd_add3(input logic [3:0] nib);
        if (nib >= 4'd5) begin
            bcd_add3 = nib + 4'd3;
        end else begin
            bcd_add3 = nib;
        end
    endfunction

endpackage

// File: rtl/bin8_to_ascii_converter_bcd_digit_to_ascii.sv
// Combinational BCD digit to ASCII character mapping.
//   bcd   in  4  BCD digit
//   ascii out 8  '0'..'9' for 0..9, '?' for 10..15
module bcd_digit_to_ascii
    import conv_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_ERR;
        if (bcd <= 4'd9) begin
            ascii = ASCII_ZERO + {4'b0000, bcd};
        end
    end

endmodule

// File: rtl/bin8_to_ascii_converter.sv
// Sequential unsigned binary to 3-digit BCD / ASCII converter using the
// shift-and-add-3 (double-dabble) method, one shift per clock.
//   clk            in   1      system clock
//   rst_n          in   1      synchronous active-low reset
//   start          in   1      conversion request, honoured only when idle
//   entrada        in   WIDTH  binary value captured with start
//   busy           out  1      conversion in progress
//   done           out  1      one-cycle pulse, results updated with it
//   unidades       out  4      BCD units digit
//   decenas        out  4      BCD tens digit
//   centenas       out  4      BCD hundreds digit
//   ascii_unidades out  8      ASCII units character
//   ascii_decenas  out  8      ASCII tens character
//   ascii_centenas out  8      ASCII hundreds character
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs hold last converted value
// SHIFT | one add-3/shift iteration per clock, WIDTH iterations
// DONE  | publish digits and ASCII, pulse done, clear busy
module bin8_to_ascii_converter
    import conv_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] entrada,
    output logic             busy,
    output logic             done,
    output logic [3:0]       unidades,
    output logic [3:0]       decenas,
    output logic [3:0]       centenas,
    output logic [7:0]       ascii_unidades,
    output logic [7:0]       ascii_decenas,
    output logic [7:0]       ascii_centenas
);

    // Three decimal digits cover at most 999, i.e. 9 input bits.
    if (WIDTH < 1 || WIDTH > 9) begin : g_bad_width
        $error("bin8_to_ascii_converter: WIDTH must be in 1..9");
    end

    localparam int         WORK_W   = 4 * BCD_DIGITS + WIDTH;
    localparam logic [3:0] CNT_LAST = 4'(WIDTH - 1);

    conv_state_e       state_q, state_d;
    logic [WORK_W-1:0] work_q, work_d;
    logic [WORK_W-1:0] work_adj;
    logic [3:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [3:0]        unidades_q, unidades_d;
    logic [3:0]        decenas_q, decenas_d;
    logic [3:0]        centenas_q, centenas_d;
    logic [7:0]        ascii_u_q, ascii_u_d;
    logic [7:0]        ascii_d_q, ascii_d_d;
    logic [7:0]        ascii_c_q, ascii_c_d;
    logic [7:0]        ascii_u_c, ascii_d_c, ascii_c_c;

    // The BCD field sits above the binary field; after WIDTH shifts it holds
    // the finished digits, which is the only time these feed the registers.
    bcd_digit_to_ascii u_conv_u (
        .bcd   (work_q[WIDTH +: 4]),
        .ascii (ascii_u_c)
    );

    bcd_digit_to_ascii u_conv_d (
        .bcd   (work_q[WIDTH + 4 +: 4]),
        .ascii (ascii_d_c)
    );

    bcd_digit_to_ascii u_conv_c (
        .bcd   (work_q[WIDTH + 8 +: 4]),
        .ascii (ascii_c_c)
    );

    always_comb begin
        work_adj = work_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            work_adj[WIDTH + 4*i +: 4] = bcd_add3(work_q[WIDTH + 4*i +: 4]);
        end
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unidades_d = unidades_q;
        decenas_d  = decenas_q;
        centenas_d = centenas_q;
        ascii_u_d  = ascii_u_q;
        ascii_d_d  = ascii_d_q;
        ascii_c_d  = ascii_c_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = {{(4*BCD_DIGITS){1'b0}}, entrada};
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = {work_adj[WORK_W-2:0], 1'b0};
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                unidades_d = work_q[WIDTH +: 4];
                decenas_d  = work_q[WIDTH + 4 +: 4];
                centenas_d = work_q[WIDTH + 8 +: 4];
                ascii_u_d  = ascii_u_c;
                ascii_d_d  = ascii_d_c;
                ascii_c_d  = ascii_c_c;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            work_q     <= '0;
            cnt_q      <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            unidades_q <= 4'h0;
            decenas_q  <= 4'h0;
            centenas_q <= 4'h0;
            ascii_u_q  <= ASCII_ZERO;
            ascii_d_q  <= ASCII_ZERO;
            ascii_c_q  <= ASCII_ZERO;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            unidades_q <= unidades_d;
            decenas_q  <= decenas_d;
            centenas_q <= centenas_d;
            ascii_u_q  <= ascii_u_d;
            ascii_d_q  <= ascii_d_d;
            ascii_c_q  <= ascii_c_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign unidades       = unidades_q;
    assign decenas        = decenas_q;
    assign centenas       = centenas_q;
    assign ascii_unidades = ascii_u_q;
    assign ascii_decenas  = ascii_d_q;
    assign ascii_centenas = ascii_c_q;

endmodule

// File: tb/tb_bin8_to_ascii_converter.sv
// Scoreboard bench for bin8_to_ascii_converter (WIDTH = 8).
module tb_bin8_to_ascii_converter;

    localparam int WIDTH   = 8;
    localparam int LATENCY = WIDTH + 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] entrada;
    logic             busy;
    logic             done;
    logic [3:0]       unidades, decenas, centenas;
    logic [7:0]       ascii_unidades, ascii_decenas, ascii_centenas;

    bin8_to_ascii_converter #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .entrada        (entrada),
        .busy           (busy),
        .done           (done),
        .unidades       (unidades),
        .decenas        (decenas),
        .centenas       (centenas),
        .ascii_unidades (ascii_unidades),
        .ascii_decenas  (ascii_decenas),
        .ascii_centenas (ascii_centenas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int value;
        int issue_edge;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse consumes one expected conversion.
    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("done_not_back_to_back", int'(prev_done), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                int   h, t, u;
                e = exp_q.pop_front();
                h = e.value / 100;
                t = (e.value / 10) % 10;
                u = e.value % 10;
                chk("latency", cyc - e.issue_edge, LATENCY);
                chk("centenas", int'(centenas), h);
                chk("decenas", int'(decenas), t);
                chk("unidades", int'(unidades), u);
                chk("ascii_centenas", int'(ascii_centenas), 48 + h);
                chk("ascii_decenas", int'(ascii_decenas), 48 + t);
                chk("ascii_unidades", int'(ascii_unidades), 48 + u);
                chk("busy_low_with_done", int'(busy), 0);
            end
        end
        prev_done = done;
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic issue(input int v);
        wait_idle();
        start   = 1'b1;
        entrada = WIDTH'(v);
        exp_q.push_back('{v, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_centenas"}, int'(centenas), 0);
        chk({tag, "_decenas"}, int'(decenas), 0);
        chk({tag, "_unidades"}, int'(unidades), 0);
        chk({tag, "_ascii_c"}, int'(ascii_centenas), 48);
        chk({tag, "_ascii_d"}, int'(ascii_decenas), 48);
        chk({tag, "_ascii_u"}, int'(ascii_unidades), 48);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        entrada = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_reset_values("reset");

        issue(8'h99);
        issue(8'hFF);
        issue(8'h0F);
        issue(8'h00);

        // start held high, entrada wandering during the conversion
        wait_idle();
        start   = 1'b1;
        entrada = 8'hC8;
        exp_q.push_back('{200, cyc + 1});
        for (int i = 0; i < LATENCY + 1; i++) begin
            @(negedge clk);
            if (i < LATENCY) begin
                chk("held_start_busy", int'(busy), 1);
                entrada = WIDTH'($urandom);
            end else begin
                start = 1'b0;
            end
        end

        // reset in the middle of a conversion of 0xFF
        issue(8'hFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        void'(exp_q.pop_back());
        check_reset_values("abort");
        repeat (12) @(negedge clk);
        check_reset_values("abort_quiet");
        issue(8'hFF);

        for (int v = 0; v < 256; v++) issue(v);
        for (int i = 0; i < 40; i++) issue(int'($urandom_range(0, 255)));

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("queue_drained", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
